mold_msg_deframer: RTL and testbench

Byte-stream consumer in the 250 MHz domain that sits directly downstream of the MAC-to-fast-domain byte CDC. It parses MoldUDP64 payloads (20-byte header, then length-prefixed message blocks) and emits one complete message per pulse, left-aligned on a wide bus, to the book-building logic. It is the reading end of the byte stream that the CDC writes.

---
 rtl/mold_pkg.sv | 25 ++
 rtl/mold_msg_deframer.sv | 170 +++++++++++++++++
 tb/tb_mold_msg_deframer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mold_pkg.sv
// Shared types and constants for the MoldUDP64 message deframer.
package mold_pkg;

   localparam int unsigned MOLD_HDR_BYTES = 20;
   localparam int unsigned MOLD_SEQ_OFS   = 10;
   localparam int unsigned MOLD_CNT_OFS   = 18;
   localparam int unsigned MSG_LEN_W      = 16;
   localparam int unsigned SEQ_W          = 64;

   localparam logic [MSG_LEN_W-1:0] MOLD_CNT_EOS = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_BODY
   } moldState_t;

   // Heartbeat (0) and end-of-session (0xFFFF) headers carry no message blocks.
   function automatic logic isNoMsgCnt(input logic [MSG_LEN_W-1:0] cnt);
      return (cnt == '0) || (cnt == MOLD_CNT_EOS);
   endfunction

endpackage

// File: rtl/mold_msg_deframer.sv
// MoldUDP64 payload deframer: emits one left-aligned message per msgValidOut pulse.
// Optional sequence-gap detection is built when MOLD_SEQ_CHECK_EN is defined.
module mold_msg_deframer
   import mold_pkg::*;
#(
   parameter int unsigned MAX_MSG_BYTES = 48
) (
   input  logic                         clkIn,
   input  logic                         rstIn,
   input  logic                         byteValidIn,
   input  logic [7:0]                   byteIn,
   input  logic                         frameStartIn,
   output logic                         msgValidOut,
   output logic [MAX_MSG_BYTES*8-1:0]   msgDataOut,
   output logic [MSG_LEN_W-1:0]         msgLenOut,
   output logic                         msgTruncOut,
   output logic [SEQ_W-1:0]             msgSeqOut,
   output logic                         seqGapOut,
   output logic                         frameErrOut
);

   localparam int unsigned DATA_W = MAX_MSG_BYTES * 8;

   localparam logic [MSG_LEN_W-1:0] SEQ_FIRST = MSG_LEN_W'(MOLD_SEQ_OFS);
   localparam logic [MSG_LEN_W-1:0] CNT_FIRST = MSG_LEN_W'(MOLD_CNT_OFS);
   localparam logic [MSG_LEN_W-1:0] HDR_LAST  = MSG_LEN_W'(MOLD_HDR_BYTES - 1);
   localparam logic [MSG_LEN_W-1:0] MAX_LEN   = MSG_LEN_W'(MAX_MSG_BYTES);

   moldState_t             state;
   logic [MSG_LEN_W-1:0]   idx;        // byte index, shared by HDR and BODY
   logic [MSG_LEN_W-1:0]   msgCnt;     // messages remaining in the frame
   logic [MSG_LEN_W-1:0]   msgLen;
   logic [SEQ_W-1:0]       curSeq;     // header sequence, advanced per emitted message
   logic [DATA_W-1:0]      msgBuf;

   logic                   accept_c;
   logic [MSG_LEN_W-1:0]   cntFull_c;
   logic [MSG_LEN_W-1:0]   lenFull_c;
   logic [DATA_W-1:0]      bodyBuf_c;
   logic                   emit_c;

   assign accept_c  = byteValidIn && !frameStartIn;
   assign cntFull_c = {msgCnt[7:0], byteIn};
   assign lenFull_c = {msgLen[15:8], byteIn};

   // Body buffer with the current byte merged in; bytes past the buffer are dropped.
   always_comb begin
      bodyBuf_c = msgBuf;
      for (int unsigned i = 0; i < MAX_MSG_BYTES; i++) begin
         if (idx == MSG_LEN_W'(i)) begin
            bodyBuf_c[(MAX_MSG_BYTES-1-i)*8 +: 8] = byteIn;
         end
      end
   end

   assign emit_c = accept_c &&
                   (((state == ST_LEN_LO) && (lenFull_c == '0)) ||
                    ((state == ST_BODY) && (idx == MSG_LEN_W'(msgLen - 16'd1))));

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         state       <= ST_IDLE;
         idx         <= '0;
         msgCnt      <= '0;
         msgLen      <= '0;
         curSeq      <= '0;
         msgBuf      <= '0;
         msgValidOut <= 1'b0;
         msgDataOut  <= '0;
         msgLenOut   <= '0;
         msgTruncOut <= 1'b0;
         msgSeqOut   <= '0;
         frameErrOut <= 1'b0;
      end else begin
         msgValidOut <= 1'b0;
         frameErrOut <= 1'b0;

         if (byteValidIn && frameStartIn) begin
            // A frame start always restarts parsing; mid-frame it aborts the frame.
            if (state != ST_IDLE) begin
               frameErrOut <= 1'b1;
            end
            state <= ST_HDR;
            idx   <= 16'd1;
         end else if (byteValidIn) begin
            unique case (state)
               ST_IDLE: begin
               end
               ST_HDR: begin
                  if ((idx >= SEQ_FIRST) && (idx < CNT_FIRST)) begin
                     curSeq <= {curSeq[SEQ_W-9:0], byteIn};
                  end else if (idx >= CNT_FIRST) begin
                     msgCnt <= cntFull_c;
                  end
                  if (idx == HDR_LAST) begin
                     idx   <= '0;
                     state <= isNoMsgCnt(cntFull_c) ? ST_IDLE : ST_LEN_HI;
                  end else begin
                     idx <= idx + 16'd1;
                  end
               end
               ST_LEN_HI: begin
                  msgLen <= {byteIn, 8'h00};
                  msgBuf <= '0;
                  state  <= ST_LEN_LO;
               end
               ST_LEN_LO: begin
                  msgLen <= lenFull_c;
                  idx    <= '0;
                  state  <= ST_BODY;
               end
               ST_BODY: begin
                  msgBuf <= bodyBuf_c;
                  idx    <= idx + 16'd1;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase

            // Message completion overrides the per-state next state.
            if (emit_c) begin
               msgValidOut <= 1'b1;
               msgSeqOut   <= curSeq;
               curSeq      <= curSeq + 64'd1;
               msgCnt      <= msgCnt - 16'd1;
               state       <= (msgCnt == 16'd1) ? ST_IDLE : ST_LEN_HI;
               if (state == ST_BODY) begin
                  msgDataOut  <= bodyBuf_c;
                  msgLenOut   <= msgLen;
                  msgTruncOut <= (msgLen > MAX_LEN);
               end else begin
                  msgDataOut  <= '0;
                  msgLenOut   <= '0;
                  msgTruncOut <= 1'b0;
               end
            end
         end
      end
   end

`ifdef MOLD_SEQ_CHECK_EN
   logic [SEQ_W-1:0] expSeq;
   logic             expValid;
   logic             hdrDone_c;

   assign hdrDone_c = accept_c && (state == ST_HDR) && (idx == HDR_LAST);

   // Expected next sequence is committed only when a header completes.
   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         expSeq    <= '0;
         expValid  <= 1'b0;
         seqGapOut <= 1'b0;
      end else begin
         seqGapOut <= 1'b0;
         if (hdrDone_c) begin
            if (expValid && (curSeq != expSeq)) begin
               seqGapOut <= 1'b1;
            end
            expSeq   <= curSeq + ((cntFull_c == MOLD_CNT_EOS) ? 64'd0 : SEQ_W'(cntFull_c));
            expValid <= 1'b1;
         end
      end
   end
`else
   assign seqGapOut = 1'b0;
`endif

endmodule

// File: tb/tb_mold_msg_deframer.sv
// Scoreboard bench for mold_msg_deframer (default MAX_MSG_BYTES=48).
module tb_mold_msg_deframer;

   localparam int MAXB = 48;
   localparam int DW   = MAXB * 8;
`ifdef MOLD_SEQ_CHECK_EN
   localparam int EXP_GAPS = 1;
`else
   localparam int EXP_GAPS = 0;
`endif

   typedef struct {
      logic [15:0]   len;
      logic [DW-1:0] data;
      logic          trunc;
      logic [63:0]   seq;
   } expMsg_t;

   logic          clkIn;
   logic          rstIn;
   logic          byteValidIn;
   logic [7:0]    byteIn;
   logic          frameStartIn;
   logic          msgValidOut;
   logic [DW-1:0] msgDataOut;
   logic [15:0]   msgLenOut;
   logic          msgTruncOut;
   logic [63:0]   msgSeqOut;
   logic          seqGapOut;
   logic          frameErrOut;

   mold_msg_deframer #(.MAX_MSG_BYTES(MAXB)) dut (
      .clkIn        (clkIn),
      .rstIn        (rstIn),
      .byteValidIn  (byteValidIn),
      .byteIn       (byteIn),
      .frameStartIn (frameStartIn),
      .msgValidOut  (msgValidOut),
      .msgDataOut   (msgDataOut),
      .msgLenOut    (msgLenOut),
      .msgTruncOut  (msgTruncOut),
      .msgSeqOut    (msgSeqOut),
      .seqGapOut    (seqGapOut),
      .frameErrOut  (frameErrOut)
   );

   initial begin
      clkIn = 1'b0;
      forever #2 clkIn = ~clkIn;
   end

   int checks   = 0;
   int failures = 0;
   int msgSeen  = 0;
   int errCnt   = 0;
   int gapCnt   = 0;

   expMsg_t    expQ[$];
   logic [7:0] txQ[$];
   expMsg_t    monE;

   task automatic checkEq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on each message pulse.
   always @(negedge clkIn) begin
      if (msgValidOut === 1'b1) begin
         msgSeen++;
         if (expQ.size() == 0) begin
            checkEq("unexpected_msg", 1, 0);
         end else begin
            monE = expQ.pop_front();
            checkEq("msg_len",   msgLenOut,   monE.len);
            checkEq("msg_data",  msgDataOut,  monE.data);
            checkEq("msg_trunc", msgTruncOut, monE.trunc);
            checkEq("msg_seq",   msgSeqOut,   monE.seq);
         end
      end
      if (frameErrOut === 1'b1) errCnt++;
      if (seqGapOut === 1'b1) gapCnt++;
   end

   task automatic sendByte(input logic [7:0] b, input logic fs);
      @(negedge clkIn);
      byteValidIn  = 1'b1;
      byteIn       = b;
      frameStartIn = fs;
      @(negedge clkIn);
      byteValidIn  = 1'b0;
      frameStartIn = 1'b0;
      byteIn       = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clkIn);
   endtask

   task automatic pushHdr(input logic [63:0] seq, input logic [15:0] cnt);
      txQ.delete();
      for (int i = 0; i < 10; i++) txQ.push_back(8'(i * 3));
      for (int k = 7; k >= 0; k--) txQ.push_back(8'(seq >> (8 * k)));
      txQ.push_back(cnt[15:8]);
      txQ.push_back(cnt[7:0]);
   endtask

   task automatic pushMsg(input int len, input logic [63:0] seq, input logic [7:0] base,
                          input logic [7:0] step, input bit keep);
      expMsg_t    e;
      logic [7:0] b;
      e.data = '0;
      txQ.push_back(8'(len >> 8));
      txQ.push_back(8'(len));
      for (int i = 0; i < len; i++) begin
         b = base + 8'(i) * step;
         txQ.push_back(b);
         if (i < MAXB) e.data[DW-1-8*i -: 8] = b;
      end
      e.len   = 16'(len);
      e.trunc = (len > MAXB);
      e.seq   = seq;
      if (keep) expQ.push_back(e);
   endtask

   task automatic sendTx(input int n);
      for (int i = 0; i < n && i < txQ.size(); i++) sendByte(txQ[i], (i == 0));
   endtask

   task automatic drain(input string tag);
      repeat (8) @(negedge clkIn);
      checkEq(tag, expQ.size(), 0);
   endtask

   task automatic checkAllZero(input string tag);
      checkEq({tag, "_valid"}, msgValidOut, 0);
      checkEq({tag, "_data"},  msgDataOut,  0);
      checkEq({tag, "_len"},   msgLenOut,   0);
      checkEq({tag, "_trunc"}, msgTruncOut, 0);
      checkEq({tag, "_seq"},   msgSeqOut,   0);
      checkEq({tag, "_gap"},   seqGapOut,   0);
      checkEq({tag, "_err"},   frameErrOut, 0);
   endtask

   int gapBase;
   int errBase;

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstIn        = 1'b1;
      byteValidIn  = 1'b0;
      byteIn       = 8'h00;
      frameStartIn = 1'b0;
      repeat (3) @(negedge clkIn);
      checkAllZero("reset");
      rstIn = 1'b0;
      repeat (2) @(negedge clkIn);

      // Basic two-message frame.
      pushHdr(64'd100, 16'd2);
      pushMsg(3, 64'd100, 8'hAA, 8'h11, 1'b1);
      pushMsg(1, 64'd101, 8'hDD, 8'h00, 1'b1);
      sendTx(txQ.size());
      drain("basic_drain");

      // Heartbeat, stray byte, end-of-session: nothing emitted, no aborts.
      pushHdr(64'd102, 16'd0);
      sendTx(txQ.size());
      sendByte(8'h55, 1'b0);
      pushHdr(64'd102, 16'hFFFF);
      sendTx(txQ.size());
      drain("hb_drain");
      checkEq("hb_err", errCnt, 0);

      // Truncation followed by a short message.
      pushHdr(64'd200, 16'd2);
      pushMsg(50, 64'd200, 8'h10, 8'h01, 1'b1);
      pushMsg(2, 64'd201, 8'hE0, 8'h05, 1'b1);
      sendTx(txQ.size());
      drain("trunc_drain");
      checkEq("trunc_err", errCnt, 0);

      // Abort at body byte 5 of 10, then a clean frame.
      pushHdr(64'd300, 16'd1);
      pushMsg(10, 64'd300, 8'h30, 8'h01, 1'b0);
      sendTx(20 + 2 + 5);
      pushHdr(64'd400, 16'd1);
      pushMsg(4, 64'd400, 8'h70, 8'h03, 1'b1);
      sendTx(txQ.size());
      drain("abort_drain");
      checkEq("abort_err", errCnt, 1);

      // Zero-length message and 64-bit sequence wrap.
      pushHdr(64'hFFFF_FFFF_FFFF_FFFF, 16'd2);
      pushMsg(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 8'h00, 1'b1);
      pushMsg(3, 64'd0, 8'hC1, 8'h01, 1'b1);
      sendTx(txQ.size());
      drain("zero_drain");

      // Reset while in LEN_LO.
      pushHdr(64'd900, 16'd1);
      pushMsg(5, 64'd900, 8'h90, 8'h01, 1'b0);
      sendTx(21);
      @(negedge clkIn);
      rstIn = 1'b1;
      @(negedge clkIn);
      checkAllZero("midrst");
      @(negedge clkIn);
      rstIn = 1'b0;
      errBase = errCnt;
      gapBase = gapCnt;

      // Sequence tracking: 1/3 then 4/1 contiguous, 7/1 is a gap.
      pushHdr(64'd1, 16'd3);
      pushMsg(1, 64'd1, 8'h01, 8'h00, 1'b1);
      pushMsg(2, 64'd2, 8'h02, 8'h01, 1'b1);
      pushMsg(1, 64'd3, 8'h03, 8'h00, 1'b1);
      sendTx(txQ.size());
      pushHdr(64'd4, 16'd1);
      pushMsg(1, 64'd4, 8'h04, 8'h00, 1'b1);
      sendTx(txQ.size());
      drain("seq_ok_drain");
      checkEq("seq_ok_gap", gapCnt - gapBase, 0);
      pushHdr(64'd7, 16'd1);
      pushMsg(2, 64'd7, 8'h07, 8'h01, 1'b1);
      sendTx(txQ.size());
      drain("seq_gap_drain");
      checkEq("seq_gap", gapCnt - gapBase, EXP_GAPS);
      checkEq("post_rst_err", errCnt - errBase, 0);

      checkEq("msg_total", msgSeen, 12);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
